// File: rtl/tpi_pkg.sv
// rtl/tpi_pkg.sv - shared constants and bus FSM state type for the 6523 TPI bus interface
//
// Purpose : register index map, register-file geometry and the bus FSM state
//           encoding shared by tpi_bus_if and its sub-modules.
// Ports   : none (package).
package tpi_pkg;

  localparam int RS_W     = 3;
  localparam int NUM_REGS = 8;

  localparam int REG_PRA  = 0;
  localparam int REG_PRB  = 1;
  localparam int REG_PRC  = 2;
  localparam int REG_DDRA = 3;
  localparam int REG_DDRB = 4;
  localparam int REG_DDRC = 5;
  localparam int REG_CR   = 6;
  localparam int REG_AR   = 7;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_READ  = 2'd1;
  localparam state_t ST_WRITE = 2'd2;

endpackage

// File: rtl/tpi_bus_sync.sv
// rtl/tpi_bus_sync.sv - aligned bus input pipeline with phi2 edge detection
//
// Purpose : registers a bundle of CPU bus pins through DEPTH identical stages so
//           every pin stays mutually aligned, and derives rise/fall pulses from
//           bit 0 (phi2) of the last stage.
// Ports   : clock_i  system clock
//           reset_i  synchronous active-high reset, clears every stage
//           d_i      raw bus bundle, phi2 in bit 0
//           q_o      last pipeline stage
//           rise_o   bit 0 of q_o went 0 -> 1 this clock
//           fall_o   bit 0 of q_o went 1 -> 0 this clock
module tpi_bus_sync #(
  parameter int W     = 1,
  parameter int DEPTH = 2
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o,
  output logic         rise_o,
  output logic         fall_o
);

  logic [W-1:0] stage_q [DEPTH];
  logic         prev_q;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
      prev_q <= 1'b0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
      prev_q <= stage_q[DEPTH-1][0];
    end
  end

  assign q_o    = stage_q[DEPTH-1];
  assign rise_o = q_o[0] & ~prev_q;
  assign fall_o = ~q_o[0] & prev_q;

endmodule

// File: rtl/tpi_bus_if.sv
// rtl/tpi_bus_if.sv - 6523 TPI CPU bus interface: bus sampling, register decode, strobes
//
// Purpose : samples the asynchronous 6502-style bus into the clock domain, runs a
//           small IDLE/READ/WRITE FSM on phi2 edges, produces one-clock write
//           strobes with data and one-clock read-complete strobes, and drives
//           read data back onto the CPU bus.
// Macro   : TPI_BUS_SYNC_EN - defined: 2-stage synchronizer on all bus inputs;
//           undefined: single register stage (bus already synchronous).
// Ports   : clock   system clock (>= 8x phi2)
//           reset   synchronous active-high reset
//           phi2    CPU phase-2 clock
//           cs      chip select, active high
//           rw      1 = read, 0 = write
//           rs      register select
//           db_in   CPU data bus input
//           db_out  CPU data bus output
//           db_oe   CPU data bus output enable
//           rdata   per-register read values, register n at [8n+7:8n]
//           data_in write data to the register blocks
//           we      one-hot write strobe
//           re      one-hot read-complete strobe
module tpi_bus_if #(
  parameter int RS_W     = tpi_pkg::RS_W,
  parameter int NUM_REGS = tpi_pkg::NUM_REGS
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  phi2,
  input  logic                  cs,
  input  logic                  rw,
  input  logic [RS_W-1:0]       rs,
  input  logic [7:0]            db_in,
  output logic [7:0]            db_out,
  output logic                  db_oe,
  input  logic [8*NUM_REGS-1:0] rdata,
  output logic [7:0]            data_in,
  output logic [NUM_REGS-1:0]   we,
  output logic [NUM_REGS-1:0]   re
);

  import tpi_pkg::*;

`ifdef TPI_BUS_SYNC_EN
  localparam int SYNC_N = 2;
`else
  localparam int SYNC_N = 1;
`endif

  localparam int BUS_W = 8 + RS_W + 3;

  logic [BUS_W-1:0] bus_raw;
  logic [BUS_W-1:0] bus_s;
  logic             phi2_s;
  logic             cs_s;
  logic             rw_s;
  logic [RS_W-1:0]  rs_s;
  logic [7:0]       db_s;
  logic             rise;
  logic             fall;

  // phi2 must sit in bit 0: the sync block edge-detects that bit.
  assign bus_raw = {db_in, rs, rw, cs, phi2};

  tpi_bus_sync #(
    .W     (BUS_W),
    .DEPTH (SYNC_N)
  ) u_sync (
    .clock_i (clock),
    .reset_i (reset),
    .d_i     (bus_raw),
    .q_o     (bus_s),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  assign {db_s, rs_s, rw_s, cs_s, phi2_s} = bus_s;

  function automatic logic [NUM_REGS-1:0] onehot(input logic [RS_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

  state_t              state_q,   state_d;
  logic [RS_W-1:0]     rs_q,      rs_d;
  logic [7:0]          hold_q,    hold_d;
  logic [7:0]          data_in_q, data_in_d;
  logic [7:0]          db_out_q,  db_out_d;
  logic                db_oe_q,   db_oe_d;
  logic [NUM_REGS-1:0] we_q,      we_d;
  logic [NUM_REGS-1:0] re_q,      re_d;

  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    data_in_d = data_in_q;
    db_out_d  = db_out_q;
    db_oe_d   = db_oe_q;
    we_d      = '0;
    re_d      = '0;
    // The holding register only matters when a write completes; capturing on
    // every phi2-high clock keeps it equal to the last sample before the fall,
    // because the fall clock itself already sees phi2_s low.
    hold_d    = phi2_s ? db_s : hold_q;

    case (state_q)
      ST_IDLE: begin
        db_oe_d = 1'b0;
        if (rise && cs_s) begin
          rs_d = rs_s;
          if (rw_s) begin
            state_d  = ST_READ;
            db_out_d = rdata[{rs_s, 3'b000} +: 8];
            db_oe_d  = 1'b1;
          end else begin
            state_d = ST_WRITE;
          end
        end
      end

      ST_READ: begin
        if (!cs_s) begin
          state_d = ST_IDLE;
          db_oe_d = 1'b0;
        end else if (fall) begin
          state_d = ST_IDLE;
          db_oe_d = 1'b0;
          re_d    = onehot(rs_q);
        end else begin
          db_out_d = rdata[{rs_q, 3'b000} +: 8];
        end
      end

      ST_WRITE: begin
        if (!cs_s) begin
          state_d = ST_IDLE;
        end else if (fall) begin
          state_d   = ST_IDLE;
          data_in_d = hold_q;
          we_d      = onehot(rs_q);
        end
      end

      default: begin
        state_d = ST_IDLE;
        db_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      rs_q      <= '0;
      hold_q    <= 8'h00;
      data_in_q <= 8'h00;
      db_out_q  <= 8'h00;
      db_oe_q   <= 1'b0;
      we_q      <= '0;
      re_q      <= '0;
    end else begin
      state_q   <= state_d;
      rs_q      <= rs_d;
      hold_q    <= hold_d;
      data_in_q <= data_in_d;
      db_out_q  <= db_out_d;
      db_oe_q   <= db_oe_d;
      we_q      <= we_d;
      re_q      <= re_d;
    end
  end

  assign db_out  = db_out_q;
  assign db_oe   = db_oe_q;
  assign data_in = data_in_q;
  assign we      = we_q;
  assign re      = re_q;

endmodule

// File: tb/tb_tpi_bus_if.sv
// tb/tb_tpi_bus_if.sv - scoreboard bench for tpi_bus_if
module tb_tpi_bus_if;

`ifdef TPI_BUS_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        phi2  = 1'b0;
  logic        cs    = 1'b0;
  logic        rw    = 1'b1;
  logic [2:0]  rs    = 3'd0;
  logic [7:0]  db_in = 8'h00;
  logic [63:0] rdata = 64'h0;
  logic [7:0]  db_out;
  logic        db_oe;
  logic [7:0]  data_in;
  logic [7:0]  we;
  logic [7:0]  re;

  always #5 clock = ~clock;

  tpi_bus_if dut (
    .clock   (clock),
    .reset   (reset),
    .phi2    (phi2),
    .cs      (cs),
    .rw      (rw),
    .rs      (rs),
    .db_in   (db_in),
    .db_out  (db_out),
    .db_oe   (db_oe),
    .rdata   (rdata),
    .data_in (data_in),
    .we      (we),
    .re      (re)
  );

  typedef struct {
    bit         is_wr;
    logic [7:0] mask;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t       sb[$];
  int         cyc         = 0;
  int         n_vec       = 0;
  int         n_err       = 0;
  logic [7:0] exp_data_in = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every clock, retire scoreboard entries against observed strobes.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (sb.size() > 0 && cyc > sb[0].cyc) begin
        chk("strobe_missing", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      if ((we | re) != 8'h00) begin
        if (sb.size() == 0) begin
          chk("strobe_unexpected", {16'h0, we, re}, 32'h0);
        end else begin
          e = sb.pop_front();
          chk("strobe_cycle", cyc, e.cyc);
          if (e.is_wr) begin
            chk("we", {24'h0, we}, {24'h0, e.mask});
            chk("re_during_we", {24'h0, re}, 32'h0);
            exp_data_in = e.data;
          end else begin
            chk("re", {24'h0, re}, {24'h0, e.mask});
            chk("we_during_re", {24'h0, we}, 32'h0);
          end
        end
      end
      chk("data_in", {24'h0, data_in}, {24'h0, exp_data_in});
    end
  end

  // One bus access. Expected strobes follow from the bus rules alone: a completed
  // access (cs held, no reset) strobes register rs_v LAT edges after phi2 falls,
  // and a write carries the last byte driven while phi2 was high.
  task automatic access(input bit cs_v, input bit rw_v, input logic [2:0] rs_v,
                        input logic [7:0] d_early, input logic [7:0] d_late,
                        input int hi, input int lo, input int drop_k,
                        input int rst_k, input bit scramble);
    bit live;
    exp_t e;
    live = cs_v && (drop_k < 0) && (rst_k < 0);
    @(negedge clock);
    cs = cs_v; rw = rw_v; rs = rs_v; db_in = d_early;
    @(negedge clock);
    phi2 = 1'b1;
    for (int k = 0; k < hi; k++) begin
      @(negedge clock);
      if (k == hi / 2) begin
        db_in = d_late;
        if (scramble) begin
          rw = 1'($urandom_range(0, 1));
          rs = 3'($urandom_range(0, 7));
          if (rw_v) rdata[int'(rs_v)*8 +: 8] = 8'($urandom_range(0, 255));
        end
      end
      if (k == drop_k) cs = 1'b0;
      if (k == rst_k) begin
        reset = 1'b1;
        exp_data_in = 8'h00;
      end
      if (rst_k >= 0 && k == rst_k + 1) begin
        chk("rst_mid_db_out", {24'h0, db_out}, 32'h0);
        chk("rst_mid_db_oe", {31'h0, db_oe}, 32'h0);
        chk("rst_mid_data_in", {24'h0, data_in}, 32'h0);
        chk("rst_mid_we_re", {16'h0, we, re}, 32'h0);
      end
      if (live && rw_v && k == hi - 1) begin
        chk("read_db_oe", {31'h0, db_oe}, 32'h1);
        chk("read_db_out", {24'h0, db_out}, {24'h0, rdata[int'(rs_v)*8 +: 8]});
      end
    end
    @(negedge clock);
    phi2  = 1'b0;
    db_in = ~d_late;
    if (live) begin
      e.is_wr = !rw_v;
      e.mask  = 8'h01 << rs_v;
      e.data  = d_late;
      e.cyc   = cyc + LAT;
      sb.push_back(e);
    end
    for (int j = 0; j < lo; j++) begin
      @(negedge clock);
      if (live && rw_v && j == LAT - 1) chk("db_oe_after_fall", {31'h0, db_oe}, 32'h0);
    end
    chk("db_oe_idle", {31'h0, db_oe}, 32'h0);
    cs    = 1'b0;
    reset = 1'b0;
  endtask

  initial begin
    int hi;
    int drop;
    rdata = {32'($urandom), 32'($urandom)};
    repeat (3) @(negedge clock);
    chk("rst_db_out", {24'h0, db_out}, 32'h0);
    chk("rst_db_oe", {31'h0, db_oe}, 32'h0);
    chk("rst_data_in", {24'h0, data_in}, 32'h0);
    chk("rst_we", {24'h0, we}, 32'h0);
    chk("rst_re", {24'h0, re}, 32'h0);
    reset = 1'b0;

    repeat (3) access(1'b0, 1'b0, 3'($urandom_range(0, 7)), 8'h5C, 8'h5C, 8, 8, -1, -1, 1'b0);
    access(1'b1, 1'b0, 3'd3, 8'hA5, 8'hA5, 8, 8, -1, -1, 1'b0);
    rdata[16 +: 8] = 8'h3C;
    access(1'b1, 1'b1, 3'd2, 8'h00, 8'h00, 8, 8, -1, -1, 1'b0);
    access(1'b1, 1'b0, 3'd5, 8'h11, 8'h22, 8, 8, -1, -1, 1'b0);
    access(1'b1, 1'b0, 3'd6, 8'h77, 8'h77, 8, 8, 3, -1, 1'b0);
    access(1'b1, 1'b0, 3'd0, 8'h5A, 8'h5A, 8, 8, -1, -1, 1'b0);
    access(1'b1, 1'b0, 3'd4, 8'hC3, 8'hC3, 8, 8, -1, 2, 1'b0);
    rdata[56 +: 8] = 8'h96;
    access(1'b1, 1'b1, 3'd7, 8'h00, 8'h00, 8, 8, -1, -1, 1'b0);

    for (int i = 0; i < 60; i++) begin
      hi   = $urandom_range(6, 10);
      drop = ($urandom_range(0, 7) == 0) ? $urandom_range(0, hi - 1) : -1;
      access(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             hi, $urandom_range(6, 10), drop, -1, 1'b1);
    end

    repeat (10) @(negedge clock);
    chk("scoreboard_drained", sb.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/tpi_bus_if.md
Name: tpi_bus_if

Overview:
- CPU-side bus interface for the 6523 TPI; sits directly upstream of the port/DDR register blocks.
- Samples the asynchronous 6502-style bus (phi2, cs, rw, rs, data) into the system clock domain.
- Decodes register-select and generates one-clock write strobes with their write data, which feed the per-port DDR and port registers.
- Returns read data onto the CPU bus and pulses a per-register read strobe for read side effects such as interrupt-register clear.

Parameters:
- RS_W, 3, register-select width.
- NUM_REGS, 8, register count; must equal 2**RS_W.

Ports:
- clock  in  1  system clock; must be at least 8x phi2 frequency.
- reset  in  1  synchronous, active-high reset.
- phi2  in  1  CPU bus phase-2 clock, asynchronous to clock.
- cs  in  1  chip select, active high (board inverts /CS).
- rw  in  1  1 = read, 0 = write.
- rs  in  RS_W  register select: 0 PRA, 1 PRB, 2 PRC, 3 DDRA, 4 DDRB, 5 DDRC, 6 CR, 7 AR.
- db_in  in  8  CPU data bus input.
- db_out  out  8  CPU data bus output.
- db_oe  out  1  bus output enable; drives the top-level tristate.
- rdata  in  8*NUM_REGS  read value for each register, register n at bits [8n+7:8n].
- data_in  out  8  write data to the register blocks.
- we  out  NUM_REGS  one-hot write strobe; bit n writes register n.
- re  out  NUM_REGS  one-hot read-complete strobe.

Behaviour:
- Reset values:
  - db_out = 0x00, db_oe = 0, data_in = 0x00, we = 0, re = 0.
  - FSM state = IDLE; all sync flops cleared to 0.
- Input sampling:
  - phi2, cs, rw, rs and db_in pass through an identical N-stage pipeline so they stay mutually aligned.
  - N = 2 with BUS_SYNC_EN, N = 1 without.
  - p_now is the last pipeline stage; p_prev is p_now delayed one clock.
  - rise = p_now & ~p_prev; fall = ~p_now & p_prev.
- FSM states and transitions:
  - IDLE:
    - on rise with cs_s=1 and rw_s=1 -> READ; latch rs_s.
    - on rise with cs_s=1 and rw_s=0 -> WRITE; latch rs_s.
    - rise with cs_s=0 -> stay in IDLE.
  - READ:
    - on entry clock, db_out <= rdata slice of the latched rs, and db_oe <= 1.
    - db_out is refreshed every clock while in READ, so it tracks live pin changes.
    - on fall -> IDLE, db_oe <= 0, re[rs] pulses for one clock.
  - WRITE:
    - every clock with phi2_s=1, the aligned db_in sample is captured into a holding register.
    - on fall -> IDLE, data_in <= holding register, we[rs] pulses for one clock.
    - The captured value is the last sample taken while phi2 was high.
  - Abort: cs_s deasserting while in READ or WRITE returns the FSM to IDLE on the next clock with db_oe=0, and issues no we and no re.
- Latency, counting clock edges from the first edge that samples phi2 low:
  - with BUS_SYNC_EN, we/re assert on edge N+1 = 3;
  - without BUS_SYNC_EN, on edge 2.
- Strobe rules:
  - Exactly one bit of we or re is high for exactly one clock per access; never both in the same clock.
  - data_in holds its value until the next write.
- A phi2 high time shorter than N+1 clocks is unsupported; behaviour is then undefined but the FSM must still return to IDLE.
- rs or rw changing mid-cycle is ignored; the values latched at rise are used.
- Reset asserted mid-access: forces the reset values on the next edge and discards the pending write (no we).

Optional Feature:
- Macro: TPI_BUS_SYNC_EN.
- Defined: 2-flop metastability synchronizer on all bus inputs (N=2), as above.
- Undefined: single register stage (N=1), for a bus already synchronous to clock; one clock lower latency; FSM otherwise identical.

Decomposition:
- Shared package tpi_pkg holds:
  - register index constants REG_PRA..REG_AR (0..7);
  - RS_W, NUM_REGS;
  - FSM state typedef (IDLE, READ, WRITE).
- One natural sub-module: tpi_bus_sync.
  - Parameterised width and depth N.
  - Aligned pipeline for {phi2, cs, rw, rs, db_in}.
  - Outputs the last stage plus the rise/fall edge pulses.

Test Plan:
- Reset, then idle bus with phi2 toggling and cs=0 -> we=0, re=0, db_oe=0 throughout.
- Write, rs=3, db_in=0xA5: we=0x08 for exactly one clock; data_in=0xA5 in that clock and held afterwards; latency 3 edges after phi2 falls (BUS_SYNC_EN).
- Read, rs=2, rdata slice 2 = 0x3C:
  - db_oe=1 and db_out=0x3C while phi2 is high;
  - db_oe=0 after the fall;
  - re=0x04 for one clock.
- Write with db_in 0x11 early in phi2-high, changing to 0x22 before the fall -> data_in=0x22.
- cs drops mid-write (rs=6) -> no we pulse, state returns to IDLE; the next write, rs=0, 0x5A, gives we=0x01, data_in=0x5A.
- Reset asserted during WRITE before the fall -> no we, all outputs 0; a following read, rs=7, returns rdata slice 7 normally.
